inst_dispatcher: RTL and testbench

- Sits directly downstream of the AXI instruction receiver.
- Pops instructions through its `instruction`/`instruction_valid`/`instruction_next` interface and decodes each 64-bit word.
- Issues EXEC work to one of `NUM_UNITS` execution units over valid/ready, and tracks outstanding instruction IDs in a scoreboard.
- Returns one processing-state word per retired instruction on the receiver's `data`/`data_id`/`data_valid` inputs.

---
 rtl/hakutpu_isa_pkg.sv | 39 +++
 rtl/inst_scoreboard.sv | 50 +++++
 rtl/inst_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_inst_dispatcher.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hakutpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hakutpu_isa_pkg
// Description : Instruction encoding, status kinds and dispatcher FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package hakutpu_isa_pkg;

    localparam logic [7:0] c_OP_NOP   = 8'h00;
    localparam logic [7:0] c_OP_EXEC  = 8'h01;
    localparam logic [7:0] c_OP_FENCE = 8'h02;

    localparam int c_OPC_LSB  = 56;
    localparam int c_OPC_W    = 8;
    localparam int c_UNIT_LSB = 52;
    localparam int c_UNIT_W   = 4;
    localparam int c_OPND_LSB = 0;
    localparam int c_OPND_W   = 52;

    localparam logic [7:0] c_KIND_LOCAL   = 8'h00;
    localparam logic [7:0] c_KIND_DONE    = 8'h01;
    localparam logic [7:0] c_KIND_ILLEGAL = 8'hEE;
    localparam logic [7:0] c_KIND_BADUNIT = 8'hEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_FENCE  = 2'd2,
        ST_RETIRE = 2'd3
    } disp_state_t;

    function automatic logic [63:0] status_word(input logic [7:0] kind,
                                                input logic [7:0] opcode,
                                                input logic [7:0] st);
        return {kind, opcode, 40'd0, st};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : inst_scoreboard
// Description : Outstanding-ID bit vector with set/clear and lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_scoreboard #(
    parameter  int DEPTH = 16,
    localparam int ID_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [ID_W-1:0] set_id,
    input  logic            clr_en,
    input  logic [ID_W-1:0] clr_id,
    input  logic [ID_W-1:0] query_id,
    output logic            query_set,
    output logic            clr_hit,
    output logic            clr_spurious,
    output logic            empty
);

    logic [DEPTH-1:0] r_bits;
    logic [DEPTH-1:0] w_set_mask;
    logic [DEPTH-1:0] w_clr_mask;

    assign query_set    = r_bits[query_id];
    assign clr_hit      = clr_en && r_bits[clr_id];
    assign clr_spurious = clr_en && !r_bits[clr_id];
    assign empty        = (r_bits == '0);

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en) w_set_mask[set_id] = 1'b1;
        if (clr_hit) w_clr_mask[clr_id] = 1'b1;
    end

    // A set and a clear never target the same bit: issue waits for a clear bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bits <= '0;
        end else begin
            r_bits <= (r_bits | w_set_mask) & ~w_clr_mask;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : inst_dispatcher
// Description : Decodes receiver instructions, issues EXEC work to units,
//               tracks outstanding IDs and returns one status per retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_dispatcher
    import hakutpu_isa_pkg::*;
#(
    parameter  int DATA_WIDTH        = 64,
    parameter  int INSTRUCTION_DEPTH = 16,
    parameter  int NUM_UNITS         = 4,
    localparam int ID_W              = $clog2(INSTRUCTION_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [ID_W-1:0]       instruction_id,
    input  logic                  instruction_valid,
    output logic                  instruction_next,
    output logic [NUM_UNITS-1:0]  disp_valid,
    input  logic [NUM_UNITS-1:0]  disp_ready,
    output logic [c_OPND_W-1:0]   disp_operand,
    output logic [ID_W-1:0]       disp_id,
    input  logic                  done_valid,
    input  logic [ID_W-1:0]       done_id,
    input  logic [7:0]            done_status,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ID_W-1:0]       data_id,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  err_spurious
);

    disp_state_t            r_state;
    logic [ID_W-1:0]        r_id;
    logic [c_UNIT_W-1:0]    r_unit;
    logic [c_OPND_W-1:0]    r_operand;
    logic [7:0]             r_opcode;
    logic [7:0]             r_kind;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [ID_W-1:0]        r_data_id;
    logic                   r_data_valid;
    logic                   r_err;

    logic [c_OPC_W-1:0]     w_opcode;
    logic [c_UNIT_W-1:0]    w_unit;
    logic [c_OPND_W-1:0]    w_operand;
    logic                   w_unit_ok;
    logic                   w_id_busy;
    logic                   w_issue_req;
    logic                   w_handshake;
    logic                   w_done_hit;
    logic                   w_spurious;
    logic                   w_sb_empty;

    assign w_opcode  = instruction[c_OPC_LSB +: c_OPC_W];
    assign w_unit    = instruction[c_UNIT_LSB +: c_UNIT_W];
    assign w_operand = instruction[c_OPND_LSB +: c_OPND_W];
    assign w_unit_ok = ({28'd0, w_unit} < 32'(NUM_UNITS));

    assign instruction_next = (r_state == ST_IDLE) && instruction_valid;
    assign w_issue_req      = (r_state == ST_ISSUE) && !w_id_busy;
    assign w_handshake      = |(disp_valid & disp_ready);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_disp
        assign disp_valid[u] = w_issue_req && (r_unit == 4'(u));
    end

    assign disp_operand = r_operand;
    assign disp_id      = r_id;
    assign data         = r_data;
    assign data_id      = r_data_id;
    assign data_valid   = r_data_valid;
    assign err_spurious = r_err;
    assign busy         = (r_state != ST_IDLE) || !w_sb_empty;

    inst_scoreboard #(
        .DEPTH        (INSTRUCTION_DEPTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (w_handshake),
        .set_id       (r_id),
        .clr_en       (done_valid),
        .clr_id       (done_id),
        .query_id     (r_id),
        .query_set    (w_id_busy),
        .clr_hit      (w_done_hit),
        .clr_spurious (w_spurious),
        .empty        (w_sb_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_id         <= '0;
            r_unit       <= '0;
            r_operand    <= '0;
            r_opcode     <= '0;
            r_kind       <= '0;
            r_data       <= '0;
            r_data_id    <= '0;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            // Completions own the status port; a pending local retire waits.
            if (w_done_hit) begin
                r_data       <= DATA_WIDTH'(status_word(c_KIND_DONE, c_OP_EXEC, done_status));
                r_data_id    <= done_id;
                r_data_valid <= 1'b1;
            end
            if (w_spurious) r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (instruction_valid) begin
                        r_id      <= instruction_id;
                        r_unit    <= w_unit;
                        r_operand <= w_operand;
                        r_opcode  <= w_opcode;
                        case (w_opcode)
                            c_OP_EXEC: begin
                                if (w_unit_ok) begin
                                    r_state <= ST_ISSUE;
                                end else begin
                                    r_kind  <= c_KIND_BADUNIT;
                                    r_state <= ST_RETIRE;
                                end
                            end
                            c_OP_NOP: begin
                                r_kind  <= c_KIND_LOCAL;
                                r_state <= ST_RETIRE;
                            end
                            c_OP_FENCE: r_state <= ST_FENCE;
                            default: begin
                                r_kind  <= c_KIND_ILLEGAL;
                                r_state <= ST_RETIRE;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (w_handshake) r_state <= ST_IDLE;
                end
                ST_FENCE: begin
                    if (w_sb_empty) begin
                        r_kind  <= c_KIND_LOCAL;
                        r_state <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    if (!done_valid) begin
                        r_data       <= DATA_WIDTH'(status_word(r_kind, r_opcode, 8'h00));
                        r_data_id    <= r_id;
                        r_data_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_dispatcher
// Description : Scoreboard bench for inst_dispatcher with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] instruction;
    logic [3:0]  instruction_id;
    logic        instruction_valid;
    logic        instruction_next;
    logic [3:0]  disp_valid;
    logic [3:0]  disp_ready;
    logic [51:0] disp_operand;
    logic [3:0]  disp_id;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [7:0]  done_status;
    logic [63:0] data;
    logic [3:0]  data_id;
    logic        data_valid;
    logic        busy;
    logic        err_spurious;

    always #5 clk = ~clk;

    inst_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .instruction_id    (instruction_id),
        .instruction_valid (instruction_valid),
        .instruction_next  (instruction_next),
        .disp_valid        (disp_valid),
        .disp_ready        (disp_ready),
        .disp_operand      (disp_operand),
        .disp_id           (disp_id),
        .done_valid        (done_valid),
        .done_id           (done_id),
        .done_status       (done_status),
        .data              (data),
        .data_id           (data_id),
        .data_valid        (data_valid),
        .busy              (busy),
        .err_spurious      (err_spurious)
    );

    typedef struct {
        logic [63:0] d;
        logic [3:0]  id;
    } stat_t;

    typedef struct {
        logic [3:0]  v;
        logic [51:0] op;
        logic [3:0]  id;
    } disp_t;

    stat_t statq[$];
    disp_t dispq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input logic [63:0] d, input logic [3:0] id);
        stat_t s;
        s.d  = d;
        s.id = id;
        statq.push_back(s);
    endtask

    task automatic expect_disp(input logic [3:0] v, input logic [51:0] op, input logic [3:0] id);
        disp_t e;
        e.v  = v;
        e.op = op;
        e.id = id;
        dispq.push_back(e);
    endtask

    // Present one instruction at the head until the dispatcher pops it.
    task automatic issue(input logic [7:0] op, input logic [3:0] unit,
                         input logic [51:0] operand, input logic [3:0] id);
        bit popped;
        popped            = 1'b0;
        instruction       = {op, unit, operand};
        instruction_id    = id;
        instruction_valid = 1'b1;
        for (int i = 0; i < 50 && !popped; i++) begin
            @(negedge clk);
            popped = instruction_next;
            tick();
        end
        instruction_valid = 1'b0;
        if (!popped) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_timeout: id %0d never popped, expected instruction_next", id);
        end
    endtask

    task automatic complete(input logic [3:0] id, input logic [7:0] st);
        done_valid  = 1'b1;
        done_id     = id;
        done_status = st;
        tick();
        done_valid  = 1'b0;
    endtask

    // Monitor: status port and dispatch handshakes against the expectation queues.
    always @(negedge clk) begin
        if (data_valid) begin
            if (statq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_status: got data %h id %0d, expected none", data, data_id);
            end else begin
                stat_t e;
                e = statq.pop_front();
                chk("status_data", data, e.d);
                chk("status_id", 64'(data_id), 64'(e.id));
            end
        end
        if (disp_valid != 4'b0) begin
            if (dispq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dispatch: got disp_valid %b, expected 0000", disp_valid);
            end else if ((disp_valid & disp_ready) != 4'b0) begin
                disp_t e;
                e = dispq.pop_front();
                chk("disp_valid", 64'(disp_valid), 64'(e.v));
                chk("disp_operand", 64'(disp_operand), 64'(e.op));
                chk("disp_id", 64'(disp_id), 64'(e.id));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instruction_next"}, 64'(instruction_next), 64'd0);
        chk({tag, "_disp_valid"}, 64'(disp_valid), 64'd0);
        chk({tag, "_disp_operand"}, 64'(disp_operand), 64'd0);
        chk({tag, "_disp_id"}, 64'(disp_id), 64'd0);
        chk({tag, "_data"}, data, 64'd0);
        chk({tag, "_data_id"}, 64'(data_id), 64'd0);
        chk({tag, "_data_valid"}, 64'(data_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err_spurious"}, 64'(err_spurious), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        instruction       = '0;
        instruction_id    = '0;
        instruction_valid = 1'b0;
        disp_ready        = '0;
        done_valid        = 1'b0;
        done_id           = '0;
        done_status       = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        // Single EXEC held until the unit accepts.
        expect_disp(4'b0100, 52'h5, 4'd3);
        issue(8'h01, 4'd2, 52'h5, 4'd3);
        @(negedge clk);
        chk("exec_disp_first", 64'(disp_valid), 64'h4);
        chk("exec_busy_issue", 64'(busy), 64'd1);
        tick();
        tick();
        @(negedge clk);
        chk("exec_disp_held", 64'(disp_valid), 64'h4);
        tick();
        disp_ready = 4'b0100;
        tick();
        disp_ready = 4'b0000;
        @(negedge clk);
        chk("exec_disp_drop", 64'(disp_valid), 64'h0);
        chk("exec_busy_outstanding", 64'(busy), 64'd1);
        tick();
        expect_status(64'h0101_0000_0000_007A, 4'd3);
        complete(4'd3, 8'h7A);
        @(negedge clk);
        chk("exec_done_valid", 64'(data_valid), 64'd1);
        chk("exec_busy_fall", 64'(busy), 64'd0);
        tick();

        // NOP then illegal opcode.
        expect_status(64'h0000_0000_0000_0000, 4'd0);
        expect_status(64'hEE33_0000_0000_0000, 4'd1);
        issue(8'h00, 4'd0, 52'h0, 4'd0);
        issue(8'h33, 4'd0, 52'h0, 4'd1);
        repeat (3) tick();

        // EXEC to a unit that does not exist.
        expect_status(64'hEF01_0000_0000_0000, 4'd2);
        issue(8'h01, 4'd9, 52'h123, 4'd2);
        repeat (4) tick();

        // FENCE behind two outstanding EXECs.
        disp_ready = 4'b1111;
        expect_disp(4'b0001, 52'hAA, 4'd4);
        expect_disp(4'b0010, 52'hBB, 4'd5);
        issue(8'h01, 4'd0, 52'hAA, 4'd4);
        issue(8'h01, 4'd1, 52'hBB, 4'd5);
        issue(8'h02, 4'd0, 52'h0, 4'd6);
        repeat (5) tick();
        @(negedge clk);
        chk("fence_busy_wait", 64'(busy), 64'd1);
        chk("fence_no_status", 64'(data_valid), 64'd0);
        tick();
        expect_status(64'h0101_0000_0000_0011, 4'd4);
        complete(4'd4, 8'h11);
        expect_status(64'h0101_0000_0000_0022, 4'd5);
        complete(4'd5, 8'h22);
        expect_status(64'h0002_0000_0000_0000, 4'd6);
        repeat (4) tick();

        // NOP retire colliding with a completion.
        expect_disp(4'b1000, 52'h77, 4'd7);
        issue(8'h01, 4'd3, 52'h77, 4'd7);
        issue(8'h00, 4'd0, 52'h0, 4'd8);
        expect_status(64'h0101_0000_0000_0033, 4'd7);
        expect_status(64'h0000_0000_0000_0000, 4'd8);
        complete(4'd7, 8'h33);
        @(negedge clk);
        chk("collide_first_id", 64'(data_id), 64'd7);
        tick();
        @(negedge clk);
        chk("collide_second_valid", 64'(data_valid), 64'd1);
        chk("collide_second_id", 64'(data_id), 64'd8);
        tick();

        // Re-issue of an outstanding ID waits for its completion.
        expect_disp(4'b0001, 52'h41, 4'd4);
        expect_disp(4'b0010, 52'h42, 4'd4);
        issue(8'h01, 4'd0, 52'h41, 4'd4);
        issue(8'h01, 4'd1, 52'h42, 4'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dup_hold", 64'(disp_valid), 64'd0);
            tick();
        end
        expect_status(64'h0101_0000_0000_0044, 4'd4);
        complete(4'd4, 8'h44);
        repeat (2) tick();
        expect_status(64'h0101_0000_0000_0045, 4'd4);
        complete(4'd4, 8'h45);
        tick();

        // Spurious completion.
        complete(4'd9, 8'h55);
        @(negedge clk);
        chk("spurious_flag", 64'(err_spurious), 64'd1);
        tick();

        // Reset in the middle of an ISSUE.
        expect_disp(4'b0001, 52'hB, 4'd11);
        issue(8'h01, 4'd0, 52'hB, 4'd11);
        tick();
        disp_ready = 4'b0000;
        expect_disp(4'b0010, 52'hA, 4'd10);
        issue(8'h01, 4'd1, 52'hA, 4'd10);
        @(negedge clk);
        chk("pre_reset_disp", 64'(disp_valid), 64'h2);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_all_zero("midreset");
        dispq.delete();
        tick();
        rst = 1'b1;
        tick();
        complete(4'd11, 8'h66);
        @(negedge clk);
        chk("post_reset_spurious", 64'(err_spurious), 64'd1);
        chk("post_reset_busy", 64'(busy), 64'd0);
        tick();

        repeat (3) tick();
        chk("status_queue_drained", 64'(statq.size()), 64'd0);
        chk("disp_queue_drained", 64'(dispq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
